// File: rtl/lcd_nibble_writer.sv
// lcd_nibble_writer: sends each accepted byte to the character LCD as two
// 4-bit writes (high nibble first). Setup, enable-pulse, hold, inter-nibble
// and post-byte delays come from a single down-counter. All pin outputs are
// registered from the next state, so they change on the edge that enters
// the state.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | ready for a byte; pins hold their last values, e low
// S_SETUP_HI | high nibble and rs driven, e low, T_SETUP cycles
// S_PULSE_HI | e high for the high nibble, T_PULSE cycles
// S_HOLD_HI  | e low, data held, T_HOLD cycles
// S_GAP      | idle between nibbles, T_GAP cycles
// S_SETUP_LO | low nibble driven, e low, T_SETUP cycles
// S_PULSE_LO | e high for the low nibble, T_PULSE cycles
// S_HOLD_LO  | e low, data held, T_HOLD cycles
// S_WAIT     | post-byte settle, T_WAIT (T_LONG for clear/home commands)
module lcd_nibble_writer #(
   parameter int T_SETUP = 2,
   parameter int T_PULSE = 12,
   parameter int T_HOLD  = 1,
   parameter int T_GAP   = 50,
   parameter int T_WAIT  = 2000,
   parameter int T_LONG  = 82000,
   parameter int CNT_W   = 17
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   input  logic       in_rs,
   output logic       busy,
   output logic       sf_e,
   output logic       e,
   output logic       rs,
   output logic       rw,
   output logic       d,
   output logic       c,
   output logic       b,
   output logic       a
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_SETUP_HI,
      S_PULSE_HI,
      S_HOLD_HI,
      S_GAP,
      S_SETUP_LO,
      S_PULSE_LO,
      S_HOLD_LO,
      S_WAIT
   } state_t;

   // Counter reload values: a state lasting N cycles loads N-1 on entry.
   localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
   localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(T_PULSE - 1);
   localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
   localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(T_GAP - 1);
   localparam logic [CNT_W-1:0] LD_WAIT  = CNT_W'(T_WAIT - 1);
   localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(T_LONG - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       byte_q, byte_d;
   logic             rs_q, rs_d;
   logic             e_q, e_d;
   logic [3:0]       nib_q, nib_d;

   logic accept;
   logic cnt_done;
   logic long_wait;

   assign accept    = in_valid && (state_q == S_IDLE);
   assign cnt_done  = (cnt_q == '0);
   // Clear display (0x01) and return home (0x02/0x03) need the long settle.
   assign long_wait = !rs_q && ((byte_q == 8'h01) || (byte_q == 8'h02) ||
                                (byte_q == 8'h03));

   // State, counter and registered pin outputs; reset aborts any transfer.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         byte_q  <= '0;
         rs_q    <= 1'b0;
         e_q     <= 1'b0;
         nib_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         byte_q  <= byte_d;
         rs_q    <= rs_d;
         e_q     <= e_d;
         nib_q   <= nib_d;
      end
   end

   // Next state: count down, advance and reload on terminal count.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == S_IDLE) begin
         if (in_valid) begin
            state_d = S_SETUP_HI;
            cnt_d   = LD_SETUP;
         end
      end else if (!cnt_done) begin
         cnt_d = cnt_q - CNT_W'(1);
      end else begin
         unique case (state_q)
            S_SETUP_HI: begin state_d = S_PULSE_HI; cnt_d = LD_PULSE; end
            S_PULSE_HI: begin state_d = S_HOLD_HI;  cnt_d = LD_HOLD;  end
            S_HOLD_HI:  begin state_d = S_GAP;      cnt_d = LD_GAP;   end
            S_GAP:      begin state_d = S_SETUP_LO; cnt_d = LD_SETUP; end
            S_SETUP_LO: begin state_d = S_PULSE_LO; cnt_d = LD_PULSE; end
            S_PULSE_LO: begin state_d = S_HOLD_LO;  cnt_d = LD_HOLD;  end
            S_HOLD_LO: begin
               state_d = S_WAIT;
               cnt_d   = long_wait ? LD_LONG : LD_WAIT;
            end
            default: begin state_d = S_IDLE; cnt_d = '0; end
         endcase
      end
   end

   // Output next values: rs/nibble only load when entering a setup state.
   always_comb begin
      byte_d = byte_q;
      rs_d   = rs_q;
      nib_d  = nib_q;
      e_d    = (state_d == S_PULSE_HI) || (state_d == S_PULSE_LO);
      if (accept) begin
         byte_d = in_data;
         rs_d   = in_rs;
         nib_d  = in_data[7:4];
      end else if (state_d == S_SETUP_LO) begin
         nib_d = byte_q[3:0];
      end
   end

   assign in_ready     = (state_q == S_IDLE);
   assign busy         = !in_ready;
   assign sf_e         = 1'b1;
   assign rw           = 1'b0;
   assign e            = e_q;
   assign rs           = rs_q;
   assign {d, c, b, a} = nib_q;

endmodule
